// File: rtl/neuron_input_arbiter.sv
// Round-robin arbiter sharing the neuron's synaptic input path between channels A and B,
// with bounded bursts and a single-entry registered output stage under valid/ready backpressure.
module neuron_input_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic [DATA_W-1:0] data_a,
    output logic              gnt_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              gnt_b,
    output logic              sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic       CH_A      = 1'b0;
    localparam logic       CH_B      = 1'b1;
    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    state_t      state;
    state_t      state_n;
    logic        last;
    logic        last_n;
    logic [3:0]  burst_cnt;
    logic [3:0]  burst_cnt_n;
    logic [3:0]  cnt_inc;
    logic        can_load;
    logic        xfer;
    logic [DATA_W-1:0] sel_data;

    assign can_load = !out_valid || out_ready;
    assign gnt_a    = (state == GNT_A) && req_a && can_load;
    assign gnt_b    = (state == GNT_B) && req_b && can_load;
    assign xfer     = gnt_a || gnt_b;
    assign sel      = (state == GNT_B);
    assign busy     = (state != IDLE);
    assign sel_data = sel ? data_b : data_a;
    assign cnt_inc  = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 4'd1;

    // A stalled grant cycle transfers nothing, so it neither advances the burst nor moves the FSM.
    always_comb begin
        state_n     = state;
        last_n      = last;
        burst_cnt_n = burst_cnt;
        case (state)
            IDLE: begin
                burst_cnt_n = 4'd0;
                if (req_a && (!req_b || last == CH_B)) begin
                    state_n = GNT_A;
                end else if (req_b) begin
                    state_n = GNT_B;
                end
            end
            GNT_A: begin
                if (!req_a) begin
                    state_n = IDLE;
                    last_n  = CH_A;
                end else if (can_load) begin
                    if (cnt_inc == BURST_MAX) begin
                        burst_cnt_n = 4'd0;
                        if (req_b) begin
                            state_n = GNT_B;
                            last_n  = CH_A;
                        end
                    end else begin
                        burst_cnt_n = cnt_inc;
                    end
                end
            end
            GNT_B: begin
                if (!req_b) begin
                    state_n = IDLE;
                    last_n  = CH_B;
                end else if (can_load) begin
                    if (cnt_inc == BURST_MAX) begin
                        burst_cnt_n = 4'd0;
                        if (req_a) begin
                            state_n = GNT_A;
                            last_n  = CH_B;
                        end
                    end else begin
                        burst_cnt_n = cnt_inc;
                    end
                end
            end
            default: begin
                state_n     = IDLE;
                burst_cnt_n = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= CH_B;
            burst_cnt <= 4'd0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            burst_cnt <= burst_cnt_n;
        end
    end

    // A load in the same cycle as a consume keeps the stage full, giving one word per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_neuron_input_arbiter.sv
// Scoreboard bench for neuron_input_arbiter: expected words are queued as traffic is
// planned and checked in order as the output stage hands them downstream.
module tb_neuron_input_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0;
    logic [7:0] data_a = 8'h00;
    logic       gnt_a;
    logic       req_b = 1'b0;
    logic [7:0] data_b = 8'h00;
    logic       gnt_b;
    logic       sel;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;
    logic       busy;

    int         nChecks = 0;
    int         nFails  = 0;
    logic [7:0] expQ[$];
    int         firstGnt;
    int         lastGnt;

    neuron_input_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a), .gnt_a(gnt_a),
        .req_b(req_b), .data_b(data_b), .gnt_b(gnt_b),
        .sel(sel), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic pushSeq(input logic [7:0] base, input int first, input int count);
        for (int i = 0; i < count; i++) expQ.push_back(8'(base + 8'(first + i)));
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Each channel offers words 0xA0+i / 0xB0+i and advances only after seeing its grant.
    task automatic applyStimulus(input int nA, input int nB, input int stallStart, input int stallLen,
                                 input logic [7:0] frozen, output int fGnt, output int lGnt);
        int idxA = 0;
        int idxB = 0;
        int cyc  = 0;
        logic ga, gb, stalled;
        fGnt = -1;
        lGnt = -1;
        while ((idxA < nA || idxB < nB || expQ.size() > 0) && cyc < 200) begin
            @(negedge clk);
            req_a  = (idxA < nA);
            data_a = 8'(8'hA0 + 8'(idxA));
            req_b  = (idxB < nB);
            data_b = 8'(8'hB0 + 8'(idxB));
            stalled = (cyc >= stallStart) && (cyc < stallStart + stallLen);
            out_ready = !stalled;
            #1;
            ga = gnt_a;
            gb = gnt_b;
            checkOutput("gnt_exclusive", 32'(ga & gb), 32'd0);
            if (stalled && out_valid) begin
                checkOutput("stall_gnt", 32'(ga | gb), 32'd0);
                checkOutput("stall_data", 32'(out_data), 32'(frozen));
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) checkOutput("unexpected_word", 32'(out_data), 32'hFFFF);
                else checkOutput("out_data", 32'(out_data), 32'(expQ.pop_front()));
            end
            if (ga || gb) begin
                if (fGnt < 0) fGnt = cyc;
                lGnt = cyc;
            end
            @(posedge clk);
            if (ga) idxA++;
            if (gb) idxB++;
            cyc++;
        end
        if (cyc >= 200) checkOutput("timeout", 32'd1, 32'd0);
        req_a = 1'b0;
        req_b = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        // Reset held with channel A already requesting
        req_a  = 1'b1;
        data_a = 8'h11;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_gnt_a", 32'(gnt_a), 32'd0);
        checkOutput("rst_gnt_b", 32'(gnt_b), 32'd0);
        checkOutput("rst_sel", 32'(sel), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("idle_no_gnt", 32'(gnt_a), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("first_busy", 32'(busy), 32'd1);
        checkOutput("first_gnt_a", 32'(gnt_a), 32'd1);
        checkOutput("first_sel", 32'(sel), 32'd0);
        checkOutput("first_valid_pre", 32'(out_valid), 32'd0);
        @(negedge clk);
        req_a = 1'b0;
        #1;
        checkOutput("first_out_valid", 32'(out_valid), 32'd1);
        checkOutput("first_out_data", 32'(out_data), 32'h11);

        // Both requesting: A x4, B x4, A x4 back to back
        doReset();
        pushSeq(8'hA0, 0, 4);
        pushSeq(8'hB0, 0, 4);
        pushSeq(8'hA0, 4, 4);
        applyStimulus(8, 4, 0, 0, 8'h00, firstGnt, lastGnt);
        checkOutput("rr_span", 32'(lastGnt - firstGnt + 1), 32'd12);

        // B alone streams 10 words without a bubble at the burst boundary
        doReset();
        pushSeq(8'hB0, 0, 10);
        applyStimulus(0, 10, 0, 0, 8'h00, firstGnt, lastGnt);
        checkOutput("b_only_span", 32'(lastGnt - firstGnt + 1), 32'd10);

        // Mid-burst stall on A: output frozen on A1, burst still 4 words long
        doReset();
        pushSeq(8'hA0, 0, 4);
        pushSeq(8'hB0, 0, 4);
        pushSeq(8'hA0, 4, 2);
        applyStimulus(6, 4, 3, 3, 8'hA1, firstGnt, lastGnt);
        checkOutput("stall_span", 32'(lastGnt - firstGnt + 1), 32'd13);

        // A drops after 2 words: one IDLE cycle, then B; next tie goes to A
        doReset();
        pushSeq(8'hA0, 0, 2);
        pushSeq(8'hB0, 0, 3);
        applyStimulus(2, 3, 0, 0, 8'h00, firstGnt, lastGnt);
        checkOutput("drop_span", 32'(lastGnt - firstGnt + 1), 32'd7);
        pushSeq(8'hA0, 0, 1);
        pushSeq(8'hB0, 0, 1);
        applyStimulus(1, 1, 0, 0, 8'h00, firstGnt, lastGnt);
        checkOutput("tie_after_b_span", 32'(lastGnt - firstGnt + 1), 32'd4);

        // Asynchronous reset while GNT_B holds a word in the output stage
        doReset();
        req_b  = 1'b1;
        data_b = 8'hB7;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("prerst_valid", 32'(out_valid), 32'd1);
        checkOutput("prerst_sel", 32'(sel), 32'd1);
        checkOutput("prerst_data", 32'(out_data), 32'hB7);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_valid", 32'(out_valid), 32'd0);
        checkOutput("async_sel", 32'(sel), 32'd0);
        checkOutput("async_gnt_b", 32'(gnt_b), 32'd0);
        checkOutput("async_busy", 32'(busy), 32'd0);
        checkOutput("async_data", 32'(out_data), 32'd0);
        req_b = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pushSeq(8'hA0, 0, 1);
        pushSeq(8'hB0, 0, 1);
        applyStimulus(1, 1, 0, 0, 8'h00, firstGnt, lastGnt);
        checkOutput("post_rst_queue", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/neuron_input_arbiter.md
Name: neuron_input_arbiter

Overview:
- Round-robin arbiter sharing one synaptic input path between two requesters (channel A, channel B) feeding the neuron accumulator.
- Drives the select of the 2:1 input mux and registers the selected word into a single-entry output stage with valid/ready backpressure.
- Supports bounded bursts, so one channel cannot starve the other.

Parameters:
- DATA_W, 8, width of synaptic data words.
- MAX_BURST, 4, maximum consecutive transfers granted to one channel while the other is requesting (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_a  input  1  channel A has a valid word on data_a.
- data_a  input  DATA_W  channel A data.
- gnt_a  output  1  channel A word accepted this cycle.
- req_b  input  1  channel B has a valid word on data_b.
- data_b  input  DATA_W  channel B data.
- gnt_b  output  1  channel B word accepted this cycle.
- sel  output  1  mux select: 0 = A, 1 = B.
- out_valid  output  1  out_data holds a word.
- out_data  output  DATA_W  registered selected word.
- out_ready  input  1  downstream consumes the word this cycle.
- busy  output  1  high in GNT_A or GNT_B state.

Behaviour:
- Reset (async, any time, including mid-burst): state=IDLE, last=B (A wins first tie), burst_cnt=0, out_valid=0, out_data=0, sel=0, gnt_a=gnt_b=0, busy=0. A word held in the output stage is discarded.
- States: IDLE, GNT_A, GNT_B. All are registered. sel=1 only in GNT_B, else 0.
- can_load = !out_valid || out_ready.
- gnt_a = (state==GNT_A) && req_a && can_load. gnt_b is the symmetric term. Grants are combinational from registered state; a requester never sees a grant in IDLE.
- Transfer on req_x && gnt_x:
  - out_data <= data_x and out_valid <= 1 at the next edge.
  - burst_cnt increments, saturating at MAX_BURST.
- Output stage:
  - If out_valid && out_ready and no transfer this cycle, out_valid <= 0.
  - A simultaneous consume and load keeps out_valid=1 with the new data. Full throughput is one word per cycle.
- IDLE:
  - Only req_a: go to GNT_A.
  - Only req_b: go to GNT_B.
  - Both requesting: grant the channel != last.
  - Neither: stay in IDLE.
  - burst_cnt <= 0 on entry to any GNT state. IDLE-to-grant latency is 1 cycle.
- GNT_x, evaluated at each edge, in priority order:
  1. req_x low: go to IDLE, last <= x.
  2. burst_cnt (after this cycle's increment) == MAX_BURST and the other channel is requesting: switch directly to GNT_other, last <= x, burst_cnt <= 0. There is no IDLE bubble.
  3. burst_cnt == MAX_BURST and the other channel is idle: stay, burst_cnt <= 0.
  4. Otherwise stay.
- Backpressure: while !can_load, state and burst_cnt hold. A stalled cycle does not count toward the burst.
- Requesters must hold req_x and data_x stable until granted. Dropping req_x before the grant is legal and handled by rule 1.

Test Plan:
- Reset with req_a=1, data_a=0x11: all outputs 0. Release reset: GNT_A after 1 cycle, gnt_a=1 in that cycle, out_data=0x11 and out_valid=1 the following cycle.
- req_a and req_b held high, data_a=0xA0.., data_b=0xB0.., out_ready=1, MAX_BURST=4: output sequence A×4, B×4, A×4. sel toggles with no idle gap. gnt_a and gnt_b are never high together.
- Only req_b high for 10 words: 10 consecutive grants, with no stall at the burst boundary and out_valid continuous.
- Burst from A with out_ready=0 for 3 cycles mid-burst: gnt_a=0 and out_data frozen during the stall. The burst completes with exactly 4 A words before switching to B.
- req_a drops after 2 words while req_b is high: IDLE for one cycle, then GNT_B. Next tie after B finishes goes to A.
- Assert rst during GNT_B with out_valid=1: out_valid, sel and gnt_b go to 0 immediately (asynchronous). After release, a tie is granted to A first.
